// File: rtl/mv_engine_pkg.sv
// mv_engine_pkg: shared FSM states, BRAM layout offsets and phase lengths for the MV engine
package mv_engine_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE} state_e;
  function automatic int x_base(input int n);
    return n * n;
  endfunction
  function automatic int y_base(input int n);
    return n * n + n;
  endfunction
  function automatic int load_cycles(input int n, input int lat);
    return n * n + n + lat;
  endfunction
  function automatic int calc_cycles(input int n, input int p);
    return n * n / p + 1;
  endfunction
endpackage

// File: rtl/mv_engine_ctrl_if.sv
// mv_engine_ctrl_if: control handshake plus BRAM port of the MV engine
interface mv_engine_ctrl_if;
  logic start;
  logic transpose;
  logic busy;
  logic done;
  logic [31:0] BRAM_ADDR;
  logic [31:0] BRAM_WRDATA;
  logic [31:0] BRAM_RDDATA;
  logic [3:0] BRAM_WE;
  logic BRAM_CLK;
  modport master (
    input start, transpose, BRAM_RDDATA,
    output busy, done, BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK
  );
  modport slave (
    output start, transpose, BRAM_RDDATA,
    input busy, done, BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK
  );
endinterface

// File: rtl/mv_mac_lane.sv
// mv_mac_lane: wrapping signed multiply-accumulate lane with clear and end-of-row valid
module mv_mac_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] acc
);
  localparam int DW = DATA_WIDTH;
  logic [DW-1:0] acc_q, acc_d, prod;
  logic vld_q, vld_d;
  always_comb begin
    prod = DW'($signed(a) * $signed(b));
    acc_d = en ? (clr ? prod : acc_q + prod) : acc_q;
    vld_d = en & last;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      vld_q <= vld_d;
    end
  end
  assign vld = vld_q;
  assign acc = acc_q;
endmodule

// File: rtl/mv_engine_ctrl.sv
// mv_engine_ctrl: loads M and x from BRAM, computes M*x or M^T*x on P lanes, writes y back
module mv_engine_ctrl
  import mv_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int VECTOR_SIZE = 64,
  parameter int NUM_LANES   = 4,
  parameter int BRAM_LAT    = 1
) (
  input logic aclk,
  input logic aresetn,
  mv_engine_ctrl_if.master bus
);
  localparam int N = VECTOR_SIZE;
  localparam int P = NUM_LANES;
  localparam int DW = DATA_WIDTH;
  localparam int D = N * N / P;
  localparam int MW = $clog2(N * N);
  localparam int NW = $clog2(N);
  localparam int LOAD_LEN = load_cycles(N, BRAM_LAT);
  localparam int CALC_LEN = calc_cycles(N, P);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic tr_q, tr_d;
  logic [DW-1:0] mat_q [N*N];
  logic [DW-1:0] vec_q [N];
  logic [DW-1:0] res_q [N];
  logic cap, cap_mat;
  logic [31:0] cap_idx;
  logic [MW-1:0] mat_wa;
  logic [NW-1:0] vec_wa, col;
  logic [DW-1:0] cap_data;
  logic mac_en, mac_clr, mac_last;
  logic lane_vld [P];
  logic [DW-1:0] lane_acc [P];
  always_comb begin
    state_d = state_q;
    tr_d = tr_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_LOAD;
        tr_d = bus.transpose;
      end
      S_LOAD:  state_d = cnt_q == LOAD_LEN - 1 ? S_CALC : S_LOAD;
      S_CALC:  state_d = cnt_q == CALC_LEN - 1 ? S_WRITE : S_CALC;
      S_WRITE: state_d = cnt_q == N - 1 ? S_DONE : S_WRITE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      tr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tr_q <= tr_d;
    end
  end
  // Matrix store is banked by row mod P: bank in the address MSBs, then row/P, then column.
  always_comb begin
    cap = state_q == S_LOAD && cnt_q >= BRAM_LAT;
    cap_idx = cnt_q - BRAM_LAT;
    cap_mat = cap_idx < x_base(N);
    mat_wa = MW'((cap_idx / N % P) * D + (cap_idx / N / P) * N + cap_idx % N);
    vec_wa = NW'(cap_idx - x_base(N));
    cap_data = DW'(bus.BRAM_RDDATA);
    col = NW'(cnt_q);
    mac_en = state_q == S_CALC && cnt_q < N * N / P;
    mac_clr = col == '0;
    mac_last = col == NW'(N - 1);
  end
  // A lane's result appears one cycle after its group's last column, so the group is (cnt-1)/N.
  always_ff @(posedge aclk) begin
    if (cap && cap_mat) mat_q[mat_wa] <= cap_data;
    if (cap && !cap_mat) vec_q[vec_wa] <= cap_data;
    for (int k = 0; k < P; k++)
      if (lane_vld[k]) res_q[NW'((cnt_q - 1) / N * P + k)] <= lane_acc[k];
  end
  for (genvar k = 0; k < P; k++) begin : g_lane
    logic [MW-1:0] ra;
    always_comb ra = tr_q ? MW'((col % P) * D + (col / P) * N + cnt_q / N * P + k)
                          : MW'(k * D + cnt_q);
    mv_mac_lane #(.DATA_WIDTH(DW)) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .en      (mac_en),
      .clr     (mac_clr),
      .last    (mac_last),
      .a       (mat_q[ra]),
      .b       (vec_q[col]),
      .vld     (lane_vld[k]),
      .acc     (lane_acc[k])
    );
  end
  always_comb begin
    bus.busy = state_q != S_IDLE;
    bus.done = state_q == S_DONE;
    bus.BRAM_WE = state_q == S_WRITE ? 4'hF : 4'h0;
    bus.BRAM_WRDATA = state_q == S_WRITE ? 32'(res_q[NW'(cnt_q)]) : '0;
    bus.BRAM_ADDR = (state_q == S_LOAD && cnt_q < y_base(N)) ? cnt_q << 2 :
                    state_q == S_WRITE ? (cnt_q + y_base(N)) << 2 : '0;
  end
  assign bus.BRAM_CLK = aclk;
endmodule

// File: tb/tb_mv_engine_ctrl.sv
// tb_mv_engine_ctrl: directed checks of mv_engine_ctrl over four size/lane/latency configurations
module tb_mv_engine_ctrl;
  localparam logic [31:0] NS = {8'd4, 8'd8, 8'd4, 8'd4};
  localparam logic [31:0] PS = {8'd2, 8'd4, 8'd2, 8'd1};
  localparam logic [31:0] LS = {8'd3, 8'd1, 8'd1, 8'd1};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn_v [4];
  logic start_v [4];
  logic tr_v [4];
  logic clr_v [4];
  logic busy_v [4];
  logic done_v [4];
  logic bclk_v [4];
  logic [31:0] addr_v [4];
  logic [31:0] wdat_v [4];
  logic [3:0] we_v [4];
  logic [31:0] pipe [4][3];
  logic [31:0] ylog [4][8];
  logic [31:0] fa [4];
  logic last_w [4];
  int wcnt [4];
  int dcnt [4];
  int bad [4];
  int n_tests = 0;
  int n_fail = 0;
  mv_engine_ctrl_if ifc [4] ();
  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int N = int'(NS[i*8 +: 8]);
    localparam int P = int'(PS[i*8 +: 8]);
    localparam int L = int'(LS[i*8 +: 8]);
    assign ifc[i].start = start_v[i];
    assign ifc[i].transpose = tr_v[i];
    assign ifc[i].BRAM_RDDATA = pipe[i][L-1];
    assign busy_v[i] = ifc[i].busy;
    assign done_v[i] = ifc[i].done;
    assign bclk_v[i] = ifc[i].BRAM_CLK;
    assign addr_v[i] = ifc[i].BRAM_ADDR;
    assign wdat_v[i] = ifc[i].BRAM_WRDATA;
    assign we_v[i] = ifc[i].BRAM_WE;
    mv_engine_ctrl #(.DATA_WIDTH(32), .VECTOR_SIZE(N), .NUM_LANES(P), .BRAM_LAT(L)) u_dut (
      .aclk    (clk),
      .aresetn (rstn_v[i]),
      .bus     (ifc[i])
    );
  end
  function automatic int nof(input int i);
    logic [31:0] v = NS;
    return int'(v[i*8 +: 8]);
  endfunction
  function automatic int pof(input int i);
    logic [31:0] v = PS;
    return int'(v[i*8 +: 8]);
  endfunction
  function automatic int lof(input int i);
    logic [31:0] v = LS;
    return int'(v[i*8 +: 8]);
  endfunction
  function automatic int ybase(input int i);
    return nof(i) * nof(i) + nof(i);
  endfunction
  // Instance 0: identity / x=1..4; instance 2: all 0x7FFFFFFF / x=2; others: M[i][j]=4i+j / x=1.
  function automatic logic [31:0] rd_fn(input int i, input logic [31:0] w);
    int n = nof(i);
    if (w < 32'(n * n))
      return i == 0 ? ((w / n == w % n) ? 32'd1 : 32'd0) : i == 2 ? 32'h7FFFFFFF : w;
    return i == 0 ? w - 32'(n * n) + 1 : i == 2 ? 32'd2 : 32'd1;
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 4; i++) begin
      pipe[i][0] <= rd_fn(i, addr_v[i] >> 2);
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (clr_v[i]) begin
        wcnt[i] <= 0;
        dcnt[i] <= 0;
        bad[i] <= 0;
        last_w[i] <= 1'b0;
      end else begin
        if (we_v[i] == 4'hF) begin
          if (wcnt[i] < 8) ylog[i][wcnt[i]] <= wdat_v[i];
          if (wcnt[i] == 0) fa[i] <= addr_v[i];
          wcnt[i] <= wcnt[i] + 1;
        end
        if (done_v[i]) dcnt[i] <= dcnt[i] + 1;
        if ((we_v[i] == 4'hF && addr_v[i] != 32'((ybase(i) + wcnt[i]) * 4)) ||
            (done_v[i] && !last_w[i]) || (we_v[i] != 4'hF && we_v[i] != 4'h0) ||
            (!busy_v[i] && (addr_v[i] != 0 || wdat_v[i] != 0 || we_v[i] != 0)))
          bad[i] <= bad[i] + 1;
        last_w[i] <= we_v[i] == 4'hF && addr_v[i] == 32'((ybase(i) + nof(i) - 1) * 4);
      end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic run(input int i, input logic t, input logic [31:0] e [8], input int mid,
                     input logic hold, input string tag);
    int cyc;
    int n = nof(i);
    int bound = n * n + n + lof(i) + n * n / pof(i) + 2 + n;
    @(posedge clk); #1;
    clr_v[i] = 1'b1;
    tr_v[i] = t;
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    clr_v[i] = 1'b0;
    start_v[i] = hold;
    tr_v[i] = ~t;
    check($sformatf("%s_busy", tag), 32'(busy_v[i]), 32'd1);
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (done_v[i]) break;
      if (mid != 0) start_v[i] = cyc == mid;
    end
    check($sformatf("%s_done_seen", tag), 32'(cyc < 3000), 32'd1);
    check($sformatf("%s_cycles_in_bound", tag), 32'(cyc <= bound), 32'd1);
    check($sformatf("%s_writes", tag), 32'(wcnt[i]), 32'(n));
    check($sformatf("%s_first_addr", tag), fa[i], 32'(ybase(i) * 4));
    for (int k = 0; k < n; k++) check($sformatf("%s_y%0d", tag, k), ylog[i][k], e[k]);
    @(negedge clk);
    check($sformatf("%s_idle_busy", tag), 32'(busy_v[i]), 32'd0);
    check($sformatf("%s_done_count", tag), 32'(dcnt[i]), 32'd1);
    if (hold) begin
      @(negedge clk);
      check($sformatf("%s_restart_busy", tag), 32'(busy_v[i]), 32'd1);
      start_v[i] = 1'b0;
      @(posedge clk); #1;
      rstn_v[i] = 1'b0;
      @(posedge clk); #1;
      rstn_v[i] = 1'b1;
      check($sformatf("%s_reset_busy", tag), 32'(busy_v[i]), 32'd0);
    end else begin
      repeat (3) @(negedge clk);
      check($sformatf("%s_stay_idle", tag), 32'(busy_v[i]), 32'd0);
      check($sformatf("%s_single_done", tag), 32'(dcnt[i]), 32'd1);
    end
    check($sformatf("%s_protocol", tag), 32'(bad[i]), 32'd0);
  endtask
  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) begin
      rstn_v[i] = 1'b0;
      start_v[i] = 1'b0;
      tr_v[i] = 1'b0;
      clr_v[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d_busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst%0d_done", i), 32'(done_v[i]), 32'd0);
      check($sformatf("rst%0d_we", i), 32'(we_v[i]), 32'd0);
      check($sformatf("rst%0d_addr", i), addr_v[i], 32'd0);
      check($sformatf("rst%0d_wrdata", i), wdat_v[i], 32'd0);
    end
    check("bram_clk_follows", 32'(bclk_v[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rstn_v[i] = 1'b1;
      clr_v[i] = 1'b0;
    end
    run(0, 1'b0, '{1, 2, 3, 4, 0, 0, 0, 0}, 0, 1'b0, "ident_t0");
    run(0, 1'b1, '{1, 2, 3, 4, 0, 0, 0, 0}, 0, 1'b0, "ident_t1");
    run(1, 1'b1, '{24, 28, 32, 36, 0, 0, 0, 0}, 0, 1'b0, "ramp_t1");
    run(1, 1'b0, '{6, 22, 38, 54, 0, 0, 0, 0}, 0, 1'b0, "ramp_t0");
    run(2, 1'b0, '{32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0,
                   32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0}, 0, 1'b1, "wrap_hold");
    run(3, 1'b1, '{24, 28, 32, 36, 0, 0, 0, 0}, 25, 1'b0, "lat3_mid_start");
    run(3, 1'b0, '{6, 22, 38, 54, 0, 0, 0, 0}, 0, 1'b0, "lat3_t0");
    @(posedge clk); #1;
    clr_v[1] = 1'b1;
    tr_v[1] = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    clr_v[1] = 1'b0;
    start_v[1] = 1'b0;
    for (cyc = 0; cyc < 3000 && wcnt[1] != 2; cyc++) begin
      @(posedge clk); #1;
    end
    check("wrst_reached_write", 32'(cyc < 3000), 32'd1);
    check("wrst_we_before", 32'(we_v[1]), 32'hF);
    rstn_v[1] = 1'b0;
    @(posedge clk); #1;
    rstn_v[1] = 1'b1;
    check("wrst_we_after", 32'(we_v[1]), 32'd0);
    check("wrst_busy_after", 32'(busy_v[1]), 32'd0);
    check("wrst_addr_after", addr_v[1], 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("wrst_no_done", 32'(dcnt[1]), 32'd0);
    check("wrst_write_count", 32'(wcnt[1]), 32'd3);
    check("wrst_protocol", 32'(bad[1]), 32'd0);
    run(1, 1'b1, '{24, 28, 32, 36, 0, 0, 0, 0}, 0, 1'b0, "after_rst");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mv_engine_ctrl.md
MV_ENGINE_CTRL -- requirements
Module: mv_engine_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: element width in bits; BRAM words are 32 bits and DATA_WIDTH SHALL be at most 32.
REQ-002 Parameter VECTOR_SIZE, default 64: N, the matrix/vector dimension; a power of two in the range 4..128.
REQ-003 Parameter NUM_LANES, default 4: P, the number of parallel MAC lanes; a power of two with P <= N.
REQ-004 Parameter BRAM_LAT, default 1: BRAM read latency in cycles, 1..3.
REQ-005 aclk  in  1  the single clock; all logic is rising-edge.
REQ-006 aresetn  in  1  synchronous, active-low reset.
REQ-007 start  in  1  level sampled only in S_IDLE.
REQ-008 transpose  in  1  latched at start; 0 computes y=M*x, 1 computes y=M^T*x.
REQ-009 busy  out  1  high in every state except S_IDLE.
REQ-010 done  out  1  one-cycle pulse when the final result word is written.
REQ-011 BRAM_ADDR  out  32  byte address, equal to word index << 2.
REQ-012 BRAM_WRDATA  out  32  result word, zero-extended from DATA_WIDTH.
REQ-013 BRAM_WE  out  4  equals 4'hF during a write cycle and 0 otherwise.
REQ-014 BRAM_CLK  out  1  driven directly from aclk; there is no internal clock generator.
REQ-015 BRAM_RDDATA  in  32  read data, valid BRAM_LAT cycles after the address.

Function
REQ-016 BRAM layout: M row-major at words 0..N*N-1, x at N*N..N*N+N-1, y written to N*N+N..N*N+2N-1.
REQ-017 States SHALL be S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE, with transitions:
- S_IDLE to S_LOAD on start.
- S_LOAD to S_CALC when the last read datum has been captured.
- S_CALC to S_WRITE when all accumulators have drained.
- S_WRITE to S_DONE after N writes.
- S_DONE to S_IDLE after 1 cycle.
REQ-018 S_LOAD SHALL issue one read per cycle for addresses 0..N*N+N-1 in ascending order.
- Captured data goes to the local matrix store, banked by (row mod P), and to the local vector store.
- S_LOAD lasts exactly N*N+N+BRAM_LAT cycles.
REQ-019 S_CALC SHALL process N/P row groups; a group is P consecutive output indices, with lane k owning index g*P+k.
- Each group spends N cycles, one per column j, and every lane performs acc += A[i][j]*x[j] each cycle.
- A[i][j] is M[i][j] when transpose=0 and M[j][i] when transpose=1.
- The matrix store SHALL supply P elements per cycle in both modes.
REQ-020 Arithmetic: two's-complement signed multiply and add, with the product and sum truncated to DATA_WIDTH (wrap-around, no saturation).
REQ-021 Each lane's accumulator SHALL clear on the first column of a group with no bubble; the result is posted to the result buffer at most 2 cycles after the group's last column.
- Total S_CALC length SHALL be N*N/P + 2 cycles or fewer.
REQ-022 S_WRITE SHALL write y[0..N-1] in ascending order, one word per cycle, with BRAM_WE=4'hF and BRAM_ADDR=(N*N+N+i)<<2.
REQ-023 done SHALL be asserted in the cycle after the write of y[N-1] (the S_DONE cycle).
REQ-024 start asserted while busy SHALL be ignored; start held high through S_DONE SHALL begin a new run on the first S_IDLE cycle.
REQ-025 Outside S_LOAD and S_WRITE, BRAM_ADDR=0, BRAM_WRDATA=0 and BRAM_WE=0.
REQ-026 transpose changes while busy SHALL have no effect on the current run.

Reset
REQ-027 On aresetn=0 at a rising edge the block SHALL return to S_IDLE, whatever state it is in.
- busy=0, done=0, BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_WE=0.
- Counters and accumulators cleared; the latched transpose value is cleared to 0.
REQ-028 The contents of the local stores need no reset.
REQ-029 A reset during S_WRITE SHALL stop writes in the following cycle; there SHALL be no partial-run done.

Structure
REQ-030 Package mv_engine_pkg SHALL hold:
- the state enumeration;
- address-offset functions for the x base and the y base;
- the cycle-count constants for S_LOAD and S_CALC.
REQ-031 One sub-module, mv_mac_lane, SHALL be instantiated P times: a DATA_WIDTH multiply-accumulate with clear and a valid output.

Verification
REQ-032 N=4, P=1, M=identity, x=[1,2,3,4], transpose=0 -> y=[1,2,3,4] at words 20..23, done 1 cycle after the word-23 write.
REQ-033 N=4, P=2, M[i][j]=4i+j, x=all 1, transpose=1 -> y=[24,28,32,36]; transpose=0 -> y=[6,22,38,54].
REQ-034 N=8, P=4, M=all 0x7FFFFFFF, x=all 2 -> every y=0xFFFFFFF0 (wrapped), with no saturation.
REQ-035 start pulsed again mid-S_CALC -> ignored, exactly N writes, a single done pulse; BRAM_LAT=3 gives identical results.
REQ-036 aresetn low for 1 cycle during S_WRITE (after 2 writes) -> BRAM_WE=0 next cycle, busy=0, no done; a fresh start then completes correctly.
